ex_muldiv_ctrl: RTL and testbench
=================================

EX_MULDIV_CTRL -- requirements
Module: ex_muldiv_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock, single clock domain.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: start  input  1  request from EX decode, qualified by funct.
REQ-004 SHALL have port: funct  input  6  operation; `FUNCT_MULT / `FUNCT_MULTU / `FUNCT_DIV / `FUNCT_DIVU accepted, others ignored.
REQ-005 SHALL have port: operand_1  input  32  multiplicand / dividend.
REQ-006 SHALL have port: operand_2  input  32  multiplier / divisor.
REQ-007 SHALL have port: flush  input  1  pipeline flush, aborts the operation in flight.
REQ-008 SHALL have port: stall_req  output  1  pipeline stall request.
REQ-009 SHALL have port: busy  output  1  operation in flight.
REQ-010 SHALL have port: done  output  1  one-cycle result-valid pulse.
REQ-011 SHALL have port: hi  output  32  HI register (product high word / remainder).
REQ-012 SHALL have port: lo  output  32  LO register (product low word / quotient).
REQ-013 SHALL have parameter: ITER, default 32, iteration count; only 32 is supported.

Function
REQ-014 SHALL implement FSM states IDLE, MUL, DIV, DONE.
REQ-015 SHALL accept in IDLE when start=1 and funct is valid: latch operands and sign info, clear the 6-bit counter, go MUL or DIV.
REQ-016 SHALL ignore start with invalid funct (no state change, stall_req=0).
REQ-017 SHALL ignore start outside IDLE.
REQ-018 SHALL run signed ops on operand magnitudes, then fix sign in DONE: product sign = s1^s2, quotient sign = s1^s2, remainder sign = s1.
REQ-019 SHALL perform one shift-add (MUL) or one restoring shift-subtract (DIV) step per cycle; after ITER steps go DONE.
REQ-020 SHALL give latency for an op accepted at cycle N: done=1 at cycle N+33, with hi/lo updated on the same edge that asserts done.
REQ-021 SHALL handle DIV/DIVU with operand_2=0: skip iteration, go DONE at N+1, hi=operand_1, lo=32'hFFFFFFFF.
REQ-022 SHALL return DIV 0x80000000 / 0xFFFFFFFF as lo=0x80000000, hi=0.
REQ-023 SHALL go DONE to IDLE unconditionally after one cycle; a start in the DONE cycle is ignored.
REQ-024 SHALL drive stall_req = (IDLE & start & valid funct) | MUL | DIV (combinational); stall_req=0 in DONE so the pipeline advances.
REQ-025 SHALL drive busy = state is MUL, DIV or DONE (registered state decode).
REQ-026 SHALL hold hi/lo between completions; they change only on the edge entering DONE.
REQ-027 SHALL, on flush=1 in any state, go IDLE next edge with no done and hi/lo unchanged; flush has priority over start and over completion.

Reset
REQ-028 SHALL, while rst_n=0 (asynchronously), force state=IDLE, counter=0, hi=0, lo=0, done=0, busy=0; stall_req evaluates to 0 unless start with valid funct is asserted.
REQ-029 SHALL abort any in-flight operation on reset assertion; the first accept is possible on the first rising edge after rst_n=1.

Structure
REQ-030 SHALL take funct codes and bus widths from the shared funct.v / bus.v includes: FUNCT_MULT/MULTU/DIV/DIVU, DATA_BUS, DOUBLE_DATA_BUS.
REQ-031 SHALL keep FSM state encodings local to the module.
REQ-032 SHALL instantiate exactly one sub-module, muldiv_step (combinational single iteration: 64-bit partial + operand to next partial).

Verification
REQ-033 SHALL cover: MULTU 0xFFFFFFFF x 0xFFFFFFFF -> done at N+33, hi=0xFFFFFFFE, lo=0x00000001, stall_req high N..N+32.
REQ-034 SHALL cover: MULT 0xFFFFFFFD x 0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-035 SHALL cover: DIV 0xFFFFFFF9 / 0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100 / 7 -> lo=14, hi=2.
REQ-036 SHALL cover: DIVU 0x12345678 / 0 -> done at N+1, hi=0x12345678, lo=0xFFFFFFFF.
REQ-037 SHALL cover: flush at N+10 of a MULT -> no done, busy=0 at N+11, hi/lo keep prior values, new start at N+11 accepted.
REQ-038 SHALL cover: rst_n low at N+5 mid-DIV -> hi=lo=0, busy=0 immediately; start during DONE ignored.

Source files
------------

// File: rtl/ex_muldiv_ctrl_pkg.sv
// Shared funct codes, bus widths and sign helpers for the EX-stage multiply/divide unit.
// No logic or state of its own.
package ex_muldiv_ctrl_pkg;

  localparam int DATA_BUS        = 32;
  localparam int DOUBLE_DATA_BUS = 64;

  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

  function automatic logic funct_valid(input logic [5:0] f);
    return (f == FUNCT_MULT) || (f == FUNCT_MULTU) || (f == FUNCT_DIV) || (f == FUNCT_DIVU);
  endfunction

  function automatic logic [DATA_BUS-1:0] magnitude(input logic [DATA_BUS-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring shift-subtract divide on a 64-bit partial.
// Purely combinational, zero latency, no flow control.
module muldiv_step
  import ex_muldiv_ctrl_pkg::*;
(
  input  logic                       div_i,
  input  logic [DOUBLE_DATA_BUS-1:0] partial_i,
  input  logic [DATA_BUS-1:0]        operand_i,
  output logic [DOUBLE_DATA_BUS-1:0] partial_o
);

  localparam int DW = DATA_BUS;

  logic [DW:0] sum;
  logic [DW:0] diff;

  // MUL partial is {accumulator, remaining multiplier bits}; DIV partial is {remainder, dividend/quotient}.
  always_comb begin
    sum  = {1'b0, partial_i[2*DW-1:DW]} + (partial_i[0] ? {1'b0, operand_i} : {(DW+1){1'b0}});
    diff = partial_i[2*DW-1:DW-1] - {1'b0, operand_i};
    if (div_i) begin
      if (diff[DW]) partial_o = {partial_i[2*DW-2:0], 1'b0};
      else          partial_o = {diff[DW-1:0], partial_i[DW-2:0], 1'b1};
    end else begin
      partial_o = {sum, partial_i[DW-1:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU unit: result 33 cycles after accept (divide-by-zero: 1 cycle).
// Stalls the pipeline via stall_req while iterating; flush aborts with no done and HI/LO untouched.
module ex_muldiv_ctrl
  import ex_muldiv_ctrl_pkg::*;
#(
  parameter int ITER = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [5:0]          funct,
  input  logic [DATA_BUS-1:0] operand_1,
  input  logic [DATA_BUS-1:0] operand_2,
  input  logic                flush,
  output logic                stall_req,
  output logic                busy,
  output logic                done,
  output logic [DATA_BUS-1:0] hi,
  output logic [DATA_BUS-1:0] lo
);

  localparam int DW = DATA_BUS;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e                     state_q;
  logic [5:0]                 cnt_q;
  logic [DOUBLE_DATA_BUS-1:0] acc_q;
  logic [DOUBLE_DATA_BUS-1:0] acc_d;
  logic [DOUBLE_DATA_BUS-1:0] prod_d;
  logic [DW-1:0]              opnd_q;
  logic [DW-1:0]              hi_q;
  logic [DW-1:0]              lo_q;
  logic [DW-1:0]              quo_d;
  logic [DW-1:0]              rem_d;
  logic [DW-1:0]              mag1;
  logic [DW-1:0]              mag2;
  logic                       neg_q;
  logic                       neg_rem_q;
  logic                       done_q;
  logic                       accept;
  logic                       op_div;
  logic                       op_signed;
  logic                       s1;
  logic                       s2;
  logic                       last_step;

  assign accept    = start && funct_valid(funct);
  assign op_div    = (funct == FUNCT_DIV) || (funct == FUNCT_DIVU);
  assign op_signed = (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
  assign s1        = op_signed && operand_1[DW-1];
  assign s2        = op_signed && operand_2[DW-1];
  assign mag1      = magnitude(operand_1, s1);
  assign mag2      = magnitude(operand_2, s2);
  assign last_step = (cnt_q == 6'(ITER - 1));

  muldiv_step u_step (
    .div_i     (state_q == S_DIV),
    .partial_i (acc_q),
    .operand_i (opnd_q),
    .partial_o (acc_d)
  );

  // Sign correction is applied to the final step result on the edge that enters DONE.
  assign prod_d = neg_q ? -acc_d : acc_d;
  assign quo_d  = neg_q ? -acc_d[DW-1:0] : acc_d[DW-1:0];
  assign rem_d  = neg_rem_q ? -acc_d[2*DW-1:DW] : acc_d[2*DW-1:DW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (flush) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (accept) begin
              cnt_q     <= '0;
              neg_q     <= s1 ^ s2;
              neg_rem_q <= s1;
              opnd_q    <= op_div ? mag2 : mag1;
              acc_q     <= {{DW{1'b0}}, op_div ? mag1 : mag2};
              if (op_div && (operand_2 == '0)) begin
                state_q <= S_DONE;
                hi_q    <= operand_1;
                lo_q    <= '1;
                done_q  <= 1'b1;
              end else begin
                state_q <= op_div ? S_DIV : S_MUL;
              end
            end
          end
          S_MUL, S_DIV: begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 6'd1;
            if (last_step) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              if (state_q == S_DIV) begin
                hi_q <= rem_d;
                lo_q <= quo_d;
              end else begin
                hi_q <= prod_d[2*DW-1:DW];
                lo_q <= prod_d[DW-1:0];
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign stall_req = ((state_q == S_IDLE) && accept) || (state_q == S_MUL) || (state_q == S_DIV);
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Directed-vector bench for ex_muldiv_ctrl with hand-computed HI/LO, latency and control checks.
module tb_ex_muldiv_ctrl;

  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [5:0]  funct;
  logic [31:0] operand_1;
  logic [31:0] operand_2;
  logic        flush;
  logic        stall_req;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] last_hi = 32'h0;
  logic [31:0] last_lo = 32'h0;

  always #5 clk = ~clk;

  ex_muldiv_ctrl #(.ITER(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .funct     (funct),
    .operand_1 (operand_1),
    .operand_2 (operand_2),
    .flush     (flush),
    .stall_req (stall_req),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called 1ns after a rising edge with the DUT idle; returns in the same phase, DUT idle.
  task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input int exp_lat, input bit start_in_done);
    int lat = 0;
    bit stall_ok = 1'b1;
    bit hold_ok = 1'b1;
    funct = f; operand_1 = a; operand_2 = b; start = 1'b1;
    #1;
    chk({tag, "_stall_accept"}, 64'(stall_req), 64'd1);
    for (int k = 1; k <= 40; k++) begin
      tick();
      start = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
      if (!stall_req || !busy) stall_ok = 1'b0;
      if (hi !== last_hi || lo !== last_lo) hold_ok = 1'b0;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    chk({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    chk({tag, "_stall_busy_window"}, 64'(stall_ok), 64'd1);
    chk({tag, "_hilo_held"}, 64'(hold_ok), 64'd1);
    chk({tag, "_done_state"}, {62'd0, busy, stall_req}, 64'h2);
    last_hi = exp_hi;
    last_lo = exp_lo;
    if (start_in_done) begin
      funct = F_MULTU; start = 1'b1;
    end
    tick();
    start = 1'b0;
    chk({tag, "_after_done"}, {62'd0, busy, done}, 64'h0);
  endtask

  task automatic flush_test(input string tag, input int at);
    bit nodone = 1'b1;
    funct = F_MULT; operand_1 = 32'd5; operand_2 = 32'd6; start = 1'b1;
    for (int k = 1; k <= at; k++) begin
      tick();
      start = 1'b0;
      if (done) nodone = 1'b0;
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk({tag, "_no_done_before"}, 64'(nodone), 64'd1);
    chk({tag, "_state"}, {62'd0, busy, done}, 64'h0);
    chk({tag, "_hi_kept"}, 64'(hi), 64'(last_hi));
    chk({tag, "_lo_kept"}, 64'(lo), 64'(last_lo));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; funct = 6'h0;
    operand_1 = 32'h0; operand_2 = 32'h0;
    #3;
    chk("reset_outputs", {hi, lo}, 64'h0);
    chk("reset_flags", {61'd0, busy, done, stall_req}, 64'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    funct = 6'h20; start = 1'b1;
    #1;
    chk("bad_funct_stall", 64'(stall_req), 64'd0);
    tick();
    chk("bad_funct_busy", 64'(busy), 64'd0);
    start = 1'b0;

    run_op("multu_max",   F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33, 1'b1);
    run_op("mult_neg",    F_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 33, 1'b0);
    run_op("div_neg",     F_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 1'b0);
    run_op("divu_100_7",  F_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       33, 1'b0);
    run_op("divu_zero",   F_DIVU,  32'h12345678, 32'h0,        32'h12345678, 32'hFFFFFFFF, 1,  1'b1);
    run_op("div_ovf",     F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33, 1'b0);
    run_op("div_negneg",  F_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 33, 1'b0);
    run_op("mult_minmin", F_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 33, 1'b0);
    run_op("mult_m1m1",   F_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 33, 1'b0);

    flush_test("flush_n10", 10);
    run_op("after_flush10", F_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 33, 1'b0);
    flush_test("flush_last", 32);
    run_op("after_flush32", F_DIVU, 32'h10, 32'd3, 32'd1, 32'd5, 33, 1'b0);

    funct = F_DIVU; operand_1 = 32'd100; operand_2 = 32'd7; start = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("rst_mid_hilo", {hi, lo}, 64'h0);
    chk("rst_mid_flags", {61'd0, busy, done, stall_req}, 64'h0);
    tick();
    rst_n = 1'b1;
    last_hi = 32'h0;
    last_lo = 32'h0;
    run_op("after_reset", F_DIV, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFF2, 33, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
